link_flr_rst_seq: RTL and testbench

// Per-link FLR sequencer feeding the AFU reset input on PCIe links with no flr_rst_mgr (LINK 1+).

---
 rtl/link_flr_rst_seq_if.sv | 43 ++++
 rtl/link_flr_rst_seq.sv | 198 +++++++++++++++++++
 tb/tb_link_flr_rst_seq.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/link_flr_rst_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | link_flr_rst_seq_if : FLR req/rsp channel, TX monitor and AFU reset bundle |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface link_flr_rst_seq_if #(
  parameter int PF_W = 3,
  parameter int VF_W = 11
);
  logic            flr_req_tvalid;
  logic [PF_W-1:0] flr_req_pf;
  logic [VF_W-1:0] flr_req_vf;
  logic            flr_req_vf_active;

  logic            flr_rsp_tvalid;
  logic [PF_W-1:0] flr_rsp_pf;
  logic [VF_W-1:0] flr_rsp_vf;
  logic            flr_rsp_vf_active;

  logic            tx_tvalid;
  logic            tx_tready;
  logic            tx_tlast;

  logic            quiesce;
  logic            port_rst_n;
  logic            drain_timeout_err;
  logic            req_ovf_err;

  modport master (
    output flr_req_tvalid, flr_req_pf, flr_req_vf, flr_req_vf_active,
    output tx_tvalid, tx_tready, tx_tlast,
    input  flr_rsp_tvalid, flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active,
    input  quiesce, port_rst_n, drain_timeout_err, req_ovf_err
  );

  modport slave (
    input  flr_req_tvalid, flr_req_pf, flr_req_vf, flr_req_vf_active,
    input  tx_tvalid, tx_tready, tx_tlast,
    output flr_rsp_tvalid, flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active,
    output quiesce, port_rst_n, drain_timeout_err, req_ovf_err
  );
endinterface
`default_nettype wire

// File: rtl/link_flr_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | link_flr_rst_seq : per-link FLR sequencer - queue, drain, reset, respond   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module link_flr_rst_seq #(
  parameter int PF_W           = 3,
  parameter int VF_W           = 11,
  parameter int REQ_DEPTH      = 4,
  parameter int RST_CYCLES     = 16,
  parameter int RECOVER_CYCLES = 8,
  parameter int DRAIN_TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  link_flr_rst_seq_if.slave bus
);

  localparam int C_MAX_A = (RST_CYCLES > RECOVER_CYCLES) ? RST_CYCLES : RECOVER_CYCLES;
  localparam int C_MAX_P = (C_MAX_A > DRAIN_TIMEOUT) ? C_MAX_A : DRAIN_TIMEOUT;
  localparam int C_CNT_W = $clog2(C_MAX_P) + 1;
  localparam int C_AW    = $clog2(REQ_DEPTH);
  localparam int C_ENT_W = PF_W + VF_W + 1;

  localparam logic [C_CNT_W-1:0] C_CNT_MAX     = '1;
  localparam logic [C_CNT_W-1:0] C_RST_LAST    = C_CNT_W'(RST_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_REC_LAST    = C_CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_DRAIN_LAST  = C_CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [C_AW:0]      C_FIFO_FULL   = (C_AW+1)'(REQ_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_RESET   = 3'd2,
    ST_RECOVER = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_ENT_W-1:0]   hold_q, hold_d;

  logic [C_ENT_W-1:0]   mem_q [REQ_DEPTH];
  logic [C_ENT_W-1:0]   mem_d [REQ_DEPTH];
  logic [C_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [C_AW:0]        count_q, count_d;

  logic                 pkt_open_q, pkt_open_d;
  logic                 port_rst_n_q, port_rst_n_d;
  logic                 quiesce_q, quiesce_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic [C_ENT_W-1:0]   rsp_ent_q, rsp_ent_d;
  logic                 drain_err_q, drain_err_d;
  logic                 ovf_err_q, ovf_err_d;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_ovf;
  logic                 w_tx_beat;
  logic [C_ENT_W-1:0]   w_req_ent;

  assign w_req_ent = {bus.flr_req_pf, bus.flr_req_vf, bus.flr_req_vf_active};
  assign w_full    = (count_q == C_FIFO_FULL);
  assign w_empty   = (count_q == '0);
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign w_push    = bus.flr_req_tvalid && (!w_full || w_pop);
  assign w_ovf     = bus.flr_req_tvalid && w_full && !w_pop;
  assign w_tx_beat = bus.tx_tvalid && bus.tx_tready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + C_AW'(w_push);
    rd_ptr_d = rd_ptr_q + C_AW'(w_pop);
    count_d  = count_q + (C_AW+1)'(w_push) - (C_AW+1)'(w_pop);
    if (w_push) begin
      mem_d[wr_ptr_q] = w_req_ent;
    end
  end

  always_comb begin
    pkt_open_d = pkt_open_q;
    if (w_tx_beat) begin
      pkt_open_d = !bus.tx_tlast;
    end
    if (!port_rst_n_q) begin
      pkt_open_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + C_CNT_W'(1);
    hold_d      = hold_q;
    drain_err_d = drain_err_q;
    ovf_err_d   = ovf_err_q | w_ovf;
    w_pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          hold_d  = mem_q[rd_ptr_q];
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        // Exit on the beat that closes the packet, not one cycle later.
        if (!pkt_open_d) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end else if (cnt_q == C_DRAIN_LAST) begin
          state_d     = ST_RESET;
          cnt_d       = '0;
          drain_err_d = 1'b1;
        end
      end
      ST_RESET: begin
        if (cnt_q == C_RST_LAST) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == C_REC_LAST) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered off the next state so they line up with state_q.
  always_comb begin
    port_rst_n_d = (state_d != ST_RESET);
    quiesce_d    = (state_d == ST_DRAIN) || (state_d == ST_RESET);
    rsp_vld_d    = (state_d == ST_RESP);
    rsp_ent_d    = rsp_vld_d ? hold_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      for (int i = 0; i < REQ_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_open_q   <= 1'b0;
      port_rst_n_q <= 1'b0;
      quiesce_q    <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_ent_q    <= '0;
      drain_err_q  <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pkt_open_q   <= pkt_open_d;
      port_rst_n_q <= port_rst_n_d;
      quiesce_q    <= quiesce_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_ent_q    <= rsp_ent_d;
      drain_err_q  <= drain_err_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign bus.flr_rsp_tvalid    = rsp_vld_q;
  assign bus.flr_rsp_pf        = rsp_ent_q[C_ENT_W-1 -: PF_W];
  assign bus.flr_rsp_vf        = rsp_ent_q[VF_W:1];
  assign bus.flr_rsp_vf_active = rsp_ent_q[0];
  assign bus.quiesce           = quiesce_q;
  assign bus.port_rst_n        = port_rst_n_q;
  assign bus.drain_timeout_err = drain_err_q;
  assign bus.req_ovf_err       = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_link_flr_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_link_flr_rst_seq : scoreboard bench for the per-link FLR sequencer      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_link_flr_rst_seq;
  localparam int PF_W = 3;
  localparam int VF_W = 11;

  typedef struct packed {
    logic [PF_W-1:0] pf;
    logic [VF_W-1:0] vf;
    logic            act;
    logic [31:0]     rel;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  rsp_t exp_q[$];
  rsp_t got_q[$];
  int   fall_rel, rise_rel, q_rel, derr_rel, ovf_rel, low_cnt, nz_viol;

  link_flr_rst_seq_if #(.PF_W(PF_W), .VF_W(VF_W)) bus ();

  link_flr_rst_seq #(
    .PF_W(PF_W), .VF_W(VF_W), .REQ_DEPTH(4),
    .RST_CYCLES(16), .RECOVER_CYCLES(8), .DRAIN_TIMEOUT(1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired, want finish before 1000000");
    $fatal(1);
  end

  function automatic rsp_t mk(input int pf, input int vf, input int act, input int rel);
    rsp_t r;
    r.pf  = PF_W'(pf);
    r.vf  = VF_W'(vf);
    r.act = 1'(act);
    r.rel = 32'(rel);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_req(input int pf, input int vf, input int act);
    bus.flr_req_tvalid    = 1'b1;
    bus.flr_req_pf        = PF_W'(pf);
    bus.flr_req_vf        = VF_W'(vf);
    bus.flr_req_vf_active = 1'(act);
    tick(1);
    bus.flr_req_tvalid    = 1'b0;
    bus.flr_req_pf        = '0;
    bus.flr_req_vf        = '0;
    bus.flr_req_vf_active = 1'b0;
  endtask

  // Capture-only monitor: records event cycles relative to t0 and every response.
  task automatic watch(input int t0, input int n);
    int   rel;
    rsp_t r;
    fall_rel = -1; rise_rel = -1; q_rel = -1; derr_rel = -1; ovf_rel = -1;
    low_cnt = 0; nz_viol = 0;
    repeat (n) begin
      @(negedge clk);
      rel = cyc - t0;
      if (bus.port_rst_n !== 1'b1) low_cnt++;
      if (fall_rel < 0 && bus.port_rst_n === 1'b0) fall_rel = rel;
      if (fall_rel >= 0 && rise_rel < 0 && bus.port_rst_n === 1'b1) rise_rel = rel;
      if (q_rel < 0 && bus.quiesce === 1'b1) q_rel = rel;
      if (derr_rel < 0 && bus.drain_timeout_err === 1'b1) derr_rel = rel;
      if (ovf_rel < 0 && bus.req_ovf_err === 1'b1) ovf_rel = rel;
      if (bus.flr_rsp_tvalid === 1'b1) begin
        r.pf = bus.flr_rsp_pf; r.vf = bus.flr_rsp_vf; r.act = bus.flr_rsp_vf_active;
        r.rel = 32'(rel);
        got_q.push_back(r);
      end else if ({bus.flr_rsp_pf, bus.flr_rsp_vf, bus.flr_rsp_vf_active} !== '0) begin
        nz_viol++;
      end
    end
  endtask

  task automatic test_reset();
    bus.flr_req_tvalid = 1'b0; bus.flr_req_pf = '0; bus.flr_req_vf = '0;
    bus.flr_req_vf_active = 1'b0;
    bus.tx_tvalid = 1'b0; bus.tx_tready = 1'b0; bus.tx_tlast = 1'b0;
    rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    total++;
    if ({bus.port_rst_n, bus.quiesce, bus.flr_rsp_tvalid, bus.drain_timeout_err, bus.req_ovf_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got prn/q/vld/derr/ovf=%b want 00000",
               {bus.port_rst_n, bus.quiesce, bus.flr_rsp_tvalid, bus.drain_timeout_err, bus.req_ovf_err});
    end
    total++;
    if ({bus.flr_rsp_pf, bus.flr_rsp_vf, bus.flr_rsp_vf_active} !== '0) begin
      bad++;
      $display("FAIL reset_rsp_data: got %h want 0", {bus.flr_rsp_pf, bus.flr_rsp_vf, bus.flr_rsp_vf_active});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.port_rst_n !== 1'b0) begin
      bad++; $display("FAIL reset_prn_before_edge: got %b want 0", bus.port_rst_n);
    end
    @(negedge clk);
    total++;
    if (bus.port_rst_n !== 1'b1) begin
      bad++; $display("FAIL reset_prn_first_edge: got %b want 1", bus.port_rst_n);
    end
    tick(2);
  endtask

  task automatic test_single();
    int   t0;
    rsp_t e, g;
    t0 = cyc;
    exp_q.push_back(mk(2, 0, 0, 27));
    fork
      send_req(2, 0, 0);
      watch(t0, 40);
    join
    total++; if (fall_rel !== 3)  begin bad++; $display("FAIL single_fall: got %0d want 3", fall_rel); end
    total++; if (rise_rel !== 19) begin bad++; $display("FAIL single_rise: got %0d want 19", rise_rel); end
    total++; if (q_rel !== 2)     begin bad++; $display("FAIL single_quiesce: got %0d want 2", q_rel); end
    total++; if (nz_viol !== 0)   begin bad++; $display("FAIL single_rsp_zero: got %0d nonzero cycles want 0", nz_viol); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL single_rsp: got none want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL single_rsp: got %h want %h", g, e); end end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL single_extra: got %0d want 0", got_q.size()); got_q.delete(); end
    tick(2);
  endtask

  task automatic test_drain_packet();
    int   t0;
    rsp_t e, g;
    t0 = cyc;
    exp_q.push_back(mk(3, 'h155, 1, 35));
    fork
      send_req(3, 'h155, 1);
      begin
        for (int r = 0; r <= 10; r++) begin
          bus.tx_tvalid = (r == 0 || r == 3 || r == 6 || r == 8 || r == 10);
          bus.tx_tready = 1'b1;
          bus.tx_tlast  = (r == 10);
          tick(1);
        end
        bus.tx_tvalid = 1'b0; bus.tx_tlast = 1'b0;
      end
      watch(t0, 45);
    join
    total++; if (fall_rel !== 11) begin bad++; $display("FAIL drain_fall: got %0d want 11", fall_rel); end
    total++; if (low_cnt !== 16)  begin bad++; $display("FAIL drain_low_cycles: got %0d want 16", low_cnt); end
    total++; if (derr_rel !== -1) begin bad++; $display("FAIL drain_no_timeout: got %0d want -1", derr_rel); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL drain_rsp: got none want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL drain_rsp: got %h want %h", g, e); end end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL drain_extra: got %0d want 0", got_q.size()); got_q.delete(); end
    tick(2);
  endtask

  task automatic test_full_pop();
    int   t0;
    rsp_t e, g;
    t0 = cyc;
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(1, 'h10 + i, 0, 27 + 27 * i));
    fork
      begin
        send_req(1, 'h10, 0);
        tick(1);
        for (int i = 1; i <= 4; i++) send_req(1, 'h10 + i, 0);
        tick(22);
        send_req(1, 'h15, 0);
      end
      watch(t0, 170);
    join
    total++; if (ovf_rel !== -1) begin bad++; $display("FAIL fullpop_ovf: got %0d want -1", ovf_rel); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL fullpop_rsp: got none want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL fullpop_rsp: got %h want %h", g, e); end end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL fullpop_extra: got %0d want 0", got_q.size()); got_q.delete(); end
    tick(2);
  endtask

  task automatic test_overflow();
    int   t0;
    rsp_t e, g;
    t0 = cyc;
    for (int i = 1; i <= 5; i++) exp_q.push_back(mk(4, i, 1, 27 * i));
    fork
      for (int i = 1; i <= 6; i++) send_req(4, i, 1);
      watch(t0, 145);
    join
    total++; if (ovf_rel !== 6) begin bad++; $display("FAIL ovf_set: got %0d want 6", ovf_rel); end
    total++; if (bus.req_ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", bus.req_ovf_err); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL ovf_rsp: got none want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL ovf_rsp: got %h want %h", g, e); end end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL ovf_extra: got %0d want 0", got_q.size()); got_q.delete(); end
    tick(2);
  endtask

  task automatic test_timeout();
    int   t0;
    rsp_t e, g;
    t0 = cyc;
    exp_q.push_back(mk(6, 'h3FF, 1, 1050));
    fork
      send_req(6, 'h3FF, 1);
      begin
        bus.tx_tvalid = 1'b1; bus.tx_tready = 1'b1; bus.tx_tlast = 1'b0;
        tick(1);
        bus.tx_tready = 1'b0;
      end
      watch(t0, 1060);
    join
    bus.tx_tvalid = 1'b0;
    total++; if (fall_rel !== 1026) begin bad++; $display("FAIL timeout_fall: got %0d want 1026", fall_rel); end
    total++; if (derr_rel !== 1026) begin bad++; $display("FAIL timeout_err: got %0d want 1026", derr_rel); end
    total++; if (rise_rel !== 1042) begin bad++; $display("FAIL timeout_rise: got %0d want 1042", rise_rel); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL timeout_rsp: got none want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL timeout_rsp: got %h want %h", g, e); end end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL timeout_extra: got %0d want 0", got_q.size()); got_q.delete(); end
    tick(2);
  endtask

  task automatic test_midseq_reset();
    int t0;
    send_req(7, 'h0AA, 1);
    send_req(7, 'h0AB, 1);
    tick(8);
    total++; if (bus.port_rst_n !== 1'b0) begin bad++; $display("FAIL abort_in_reset: got %b want 0", bus.port_rst_n); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.quiesce !== 1'b0) begin bad++; $display("FAIL abort_quiesce: got %b want 0", bus.quiesce); end
    total++; if (bus.drain_timeout_err !== 1'b0) begin bad++; $display("FAIL abort_derr: got %b want 0", bus.drain_timeout_err); end
    total++; if (bus.req_ovf_err !== 1'b0) begin bad++; $display("FAIL abort_ovf: got %b want 0", bus.req_ovf_err); end
    tick(3);
    rst_n = 1'b1;
    t0 = cyc;
    watch(t0, 60);
    total++; if (rise_rel !== 1) begin bad++; $display("FAIL abort_release: got %0d want 1", rise_rel); end
    total++; if (low_cnt !== 1)  begin bad++; $display("FAIL abort_low_cycles: got %0d want 1", low_cnt); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL abort_no_rsp: got %0d want 0", got_q.size()); got_q.delete(); end
    tick(1);
  endtask

  task automatic test_post_reset();
    int   t0;
    rsp_t e, g;
    t0 = cyc;
    exp_q.push_back(mk(5, 'h7AB, 1, 27));
    fork
      send_req(5, 'h7AB, 1);
      watch(t0, 40);
    join
    total++; if (fall_rel !== 3) begin bad++; $display("FAIL post_fall: got %0d want 3", fall_rel); end
    total++; if (low_cnt !== 16) begin bad++; $display("FAIL post_low_cycles: got %0d want 16", low_cnt); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); total++;
      if (got_q.size() == 0) begin bad++; $display("FAIL post_rsp: got none want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL post_rsp: got %h want %h", g, e); end end
    end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL post_extra: got %0d want 0", got_q.size()); got_q.delete(); end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_drain_packet();
    test_full_pop();
    test_overflow();
    test_timeout();
    test_midseq_reset();
    test_post_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
